// File: rtl/gsro_round_engine.sv
// gsro_round_engine: round-based stochastic update engine for a Boolean rule network.
// Each round visits every element once, in LFSR-random order. The visited bit is written
// from an external rule evaluator, with knock-out (inhibit) and knock-in (force) masks applied.
// Optional feature macro: GSRO_SYNC_MODE_EN adds a synchronous update mode. In that mode the
// index order is fixed and writes go to a shadow register that is committed at round end.
module gsro_round_engine #(
  parameter int RULES         = 32,
  parameter int LOG_RULES     = 5,
  parameter int ROUND_W       = 10,
  parameter int STEADY_ROUNDS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [63:0]          seed,
  input  logic [RULES-1:0]     init_state,
  input  logic [RULES-1:0]     inhibit_mask,
  input  logic [RULES-1:0]     force_mask,
  input  logic [ROUND_W-1:0]   max_rounds,
  input  logic                 sync_mode,
  output logic [LOG_RULES-1:0] rule_idx,
  input  logic                 next_bit,
  output logic [RULES-1:0]     network_state,
  output logic [ROUND_W-1:0]   round_number,
  output logic                 busy,
  output logic                 done,
  output logic                 steady_state,
  output logic                 timeout
);

  localparam int STW = $clog2(STEADY_ROUNDS + 1);
  // Galois right-shift toggle mask for x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [LOG_RULES:0] RULES_L = (LOG_RULES + 1)'(RULES);
  localparam logic [RULES-1:0] IDX_ONE = RULES'(1);
  localparam logic [STW-1:0] STEADY_L = STW'(STEADY_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_UPDATE,
    S_ROUND_END,
    S_DONE
  } fsm_t;

  fsm_t                 r_fsm;
  logic [63:0]          r_lfsr;
  logic [RULES-1:0]     r_state;
  logic [RULES-1:0]     r_last;
  logic [RULES-1:0]     r_updated;
  logic [RULES-1:0]     r_inhibit;
  logic [RULES-1:0]     r_force;
  logic [ROUND_W-1:0]   r_max;
  logic [ROUND_W-1:0]   r_round;
  logic [STW-1:0]       r_stable;
  logic [LOG_RULES-1:0] r_rule_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_steady;
  logic                 r_timeout;

  logic [63:0]          w_lfsr_next;
  logic [LOG_RULES-1:0] w_cand;
  logic                 w_cand_ok;
  logic                 w_masked_bit;
  logic [RULES-1:0]     w_upd_next;
  logic                 w_all_done;
  logic [RULES-1:0]     w_init_masked;
  logic [RULES-1:0]     w_commit;
  logic [ROUND_W-1:0]   w_round_inc;
  logic [STW-1:0]       w_stable_inc;
  logic                 w_sync;

`ifdef GSRO_SYNC_MODE_EN
  logic                 r_sync;
  logic [RULES-1:0]     r_shadow;
  assign w_sync   = r_sync;
  // In synchronous mode the round result lives in the shadow until round end
  assign w_commit = r_sync ? r_shadow : r_state;
`else
  logic w_unused_sync;
  assign w_unused_sync = sync_mode;
  assign w_sync   = 1'b0;
  assign w_commit = r_state;
`endif

  assign w_lfsr_next   = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
  assign w_cand        = r_lfsr[LOG_RULES-1:0];
  assign w_cand_ok     = ({1'b0, w_cand} < RULES_L) && !r_updated[w_cand];
  assign w_masked_bit  = (next_bit | r_force[r_rule_idx]) & ~r_inhibit[r_rule_idx];
  assign w_upd_next    = r_updated | (IDX_ONE << r_rule_idx);
  assign w_all_done    = &w_upd_next;
  assign w_init_masked = (init_state | force_mask) & ~inhibit_mask;
  assign w_round_inc   = (&r_round) ? r_round : r_round + ROUND_W'(1);
  assign w_stable_inc  = (w_commit == r_last) ? r_stable + STW'(1) : '0;

  assign rule_idx      = r_rule_idx;
  assign network_state = r_state;
  assign round_number  = r_round;
  assign busy          = r_busy;
  assign done          = r_done;
  assign steady_state  = r_steady;
  assign timeout       = r_timeout;

  // Run control FSM: start/abort handling, element selection, update and round bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm      <= S_IDLE;
      r_lfsr     <= 64'd1;
      r_state    <= '0;
      r_last     <= '0;
      r_updated  <= '0;
      r_inhibit  <= '0;
      r_force    <= '0;
      r_max      <= '0;
      r_round    <= '0;
      r_stable   <= '0;
      r_rule_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_steady   <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef GSRO_SYNC_MODE_EN
      r_sync     <= 1'b0;
      r_shadow   <= '0;
`endif
    end else if (abort) begin
      r_fsm     <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_steady  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr     <= (seed == 64'd0) ? 64'd1 : seed;
            r_inhibit  <= inhibit_mask;
            r_force    <= force_mask;
            r_max      <= max_rounds;
            r_state    <= w_init_masked;
            r_last     <= w_init_masked;
            r_updated  <= '0;
            r_round    <= '0;
            r_stable   <= '0;
            r_rule_idx <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_steady   <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef GSRO_SYNC_MODE_EN
            r_sync     <= sync_mode;
            r_shadow   <= w_init_masked;
            r_fsm      <= sync_mode ? S_UPDATE : S_SELECT;
`else
            r_fsm      <= S_SELECT;
`endif
          end
        end
        S_SELECT: begin
          r_lfsr <= w_lfsr_next;
          if (w_cand_ok) begin
            r_rule_idx <= w_cand;
            r_fsm      <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_updated <= w_upd_next;
`ifdef GSRO_SYNC_MODE_EN
          if (r_sync) begin
            r_shadow[r_rule_idx] <= w_masked_bit;
          end else begin
            r_state[r_rule_idx] <= w_masked_bit;
          end
`else
          r_state[r_rule_idx] <= w_masked_bit;
`endif
          if (w_all_done) begin
            r_fsm <= S_ROUND_END;
          end else if (w_sync) begin
            r_rule_idx <= r_rule_idx + LOG_RULES'(1);
          end else begin
            r_fsm <= S_SELECT;
          end
        end
        S_ROUND_END: begin
          r_round   <= w_round_inc;
          r_stable  <= w_stable_inc;
          r_last    <= w_commit;
          r_state   <= w_commit;
          r_updated <= '0;
          if (w_stable_inc == STEADY_L) begin
            r_fsm    <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_steady <= 1'b1;
          end else if ((r_max != '0) && (w_round_inc == r_max)) begin
            r_fsm     <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else if (w_sync) begin
            r_rule_idx <= '0;
            r_fsm      <= S_UPDATE;
          end else begin
            r_fsm <= S_SELECT;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsro_round_engine.sv
// Self-checking bench for gsro_round_engine (RULES=8): table-driven runs plus
// hand-written reset, abort, restart and update-mode sequences.
module tb_gsro_round_engine;

  localparam int RULES         = 8;
  localparam int LOG_RULES     = 3;
  localparam int ROUND_W       = 10;
  localparam int STEADY_ROUNDS = 2;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [63:0]          seed;
  logic [RULES-1:0]     initState;
  logic [RULES-1:0]     inhibitMask;
  logic [RULES-1:0]     forceMask;
  logic [ROUND_W-1:0]   maxRounds;
  logic                 syncMode;
  logic [LOG_RULES-1:0] ruleIdx;
  logic                 nextBit;
  logic [RULES-1:0]     networkState;
  logic [ROUND_W-1:0]   roundNumber;
  logic                 busy;
  logic                 done;
  logic                 steadyState;
  logic                 timeoutFlag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0]        seed;
    logic [RULES-1:0]   init;
    logic [RULES-1:0]   inhibitMask;
    logic [RULES-1:0]   forceMask;
    logic [ROUND_W-1:0] maxRounds;
    logic [1:0]         evalMode;
    bit                 order;
    logic [RULES-1:0]   expState;
    logic [ROUND_W-1:0] expRound;
    logic               expSteady;
    logic               expTimeout;
  } vec_t;

  vec_t vecs[6];
  vec_t extraVec;

  logic [1:0]           evalMode;
  logic [LOG_RULES-1:0] rotIdx;
  logic [LOG_RULES-1:0] expQ[$];
  bit                   orderCheck = 0;
  bit                   runWatch   = 0;
  logic [RULES-1:0]     curInhibit;
  logic [RULES-1:0]     curForce;
  logic [RULES-1:0]     prevState = '0;
  logic                 prevBusy  = 1'b0;
  logic [LOG_RULES-1:0] popIdx;
  logic [RULES-1:0]     expBit;

  gsro_round_engine #(
    .RULES(RULES), .LOG_RULES(LOG_RULES), .ROUND_W(ROUND_W), .STEADY_ROUNDS(STEADY_ROUNDS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
    .init_state(initState), .inhibit_mask(inhibitMask), .force_mask(forceMask),
    .max_rounds(maxRounds), .sync_mode(syncMode), .rule_idx(ruleIdx), .next_bit(nextBit),
    .network_state(networkState), .round_number(roundNumber), .busy(busy), .done(done),
    .steady_state(steadyState), .timeout(timeoutFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule evaluator: toggle, constant 0, constant 1, or one-step rotate left
  always_comb begin
    rotIdx = ruleIdx - 3'd1;
    case (evalMode)
      2'd0:    nextBit = ~networkState[ruleIdx];
      2'd1:    nextBit = 1'b0;
      2'd2:    nextBit = 1'b1;
      default: nextBit = networkState[rotIdx];
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] lfsrStep(input logic [63:0] v);
    return v[0] ? ((v >> 1) ^ 64'hD800_0000_0000_0000) : (v >> 1);
  endfunction

  // Reference visit order: filter the LFSR low bits, one permutation per round
  task automatic pushOrder(input logic [63:0] s, input int rounds);
    logic [63:0]          l;
    logic [RULES-1:0]     used;
    logic [LOG_RULES-1:0] c;
    l = (s == 64'd0) ? 64'd1 : s;
    for (int r = 0; r < rounds; r++) begin
      used = '0;
      while (used != 8'hFF) begin
        c = l[LOG_RULES-1:0];
        l = lfsrStep(l);
        if (!used[c]) begin
          used[c] = 1'b1;
          expQ.push_back(c);
        end
      end
    end
  endtask

  // Scoreboard and mask invariant monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (orderCheck && prevBusy && (networkState !== prevState)) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL write_order: unexpected write, state=%0h", networkState);
      end else begin
        popIdx = expQ.pop_front();
        expBit = 8'b1 << popIdx;
        checkOutput("write_order", networkState ^ prevState, expBit);
        checkOutput("rule_idx_at_write", ruleIdx, popIdx);
      end
    end
    if (runWatch && curInhibit != '0)
      checkOutput("inhibit_hold", networkState & curInhibit, '0);
    if (runWatch && curForce != '0)
      checkOutput("force_hold", networkState & curForce & ~curInhibit, curForce & ~curInhibit);
    prevState = networkState;
    prevBusy  = busy;
  end

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_wait_done: done=%b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    seed        = v.seed;
    initState   = v.init;
    inhibitMask = v.inhibitMask;
    forceMask   = v.forceMask;
    maxRounds   = v.maxRounds;
    evalMode    = v.evalMode;
    curInhibit  = v.inhibitMask;
    curForce    = v.forceMask;
    expQ.delete();
    if (v.order) pushOrder(v.seed, int'(v.expRound));
    orderCheck = v.order;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_after_start"}, busy, 1'b1);
    checkOutput({tag, "_done_after_start"}, done, 1'b0);
    runWatch = 1;
    waitDone(8000, tag);
    runWatch   = 0;
    orderCheck = 0;
    checkOutput({tag, "_state"}, networkState, v.expState);
    checkOutput({tag, "_round"}, roundNumber, v.expRound);
    checkOutput({tag, "_steady"}, steadyState, v.expSteady);
    checkOutput({tag, "_timeout"}, timeoutFlag, v.expTimeout);
    checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
    if (v.order) checkOutput({tag, "_order_drained"}, expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [RULES-1:0]   savedState;
    logic [ROUND_W-1:0] savedRound;
    int n;
    int flips;

    //          seed                    init   inh    frc    max  ev   ord  expSt  rnd  std  to
    vecs[0] = '{64'h1,                  8'h00, 8'h00, 8'h00, 10'd4, 2'd0, 1, 8'h00, 10'd4, 1'b0, 1'b1};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 8'hFF, 8'h00, 8'h00, 10'd0, 2'd1, 0, 8'h00, 10'd3, 1'b1, 1'b0};
    vecs[2] = '{64'h5,                  8'h00, 8'h01, 8'h80, 10'd0, 2'd2, 0, 8'hFE, 10'd3, 1'b1, 1'b0};
    vecs[3] = '{64'hDEAD,               8'hFF, 8'h00, 8'h00, 10'd3, 2'd1, 0, 8'h00, 10'd3, 1'b1, 1'b0};
    vecs[4] = '{64'hBEEF,               8'h0F, 8'h00, 8'h00, 10'd1, 2'd0, 1, 8'hF0, 10'd1, 1'b0, 1'b1};
    vecs[5] = '{64'h77,                 8'h00, 8'h00, 8'hFF, 10'd0, 2'd1, 0, 8'hFF, 10'd2, 1'b1, 1'b0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; initState = '0;
    inhibitMask = '0; forceMask = '0; maxRounds = '0; syncMode = 1'b0; evalMode = 2'd0;
    curInhibit = '0; curForce = '0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs",
        {busy, done, steadyState, timeoutFlag, ruleIdx, networkState, roundNumber}, '0);
    end

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    repeat (4) @(negedge clk);
    checkOutput("done_hold", done, 1'b1);
    checkOutput("done_hold_round", roundNumber, vecs[5].expRound);
    checkOutput("done_hold_state", networkState, vecs[5].expState);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_in_done_flags", {done, steadyState, timeoutFlag}, 3'b000);
    checkOutput("abort_in_done_state", networkState, vecs[5].expState);

    // Abort mid-round 2, after checking that start while busy is ignored
    seed = 64'h9; initState = 8'h00; inhibitMask = '0; forceMask = '0; maxRounds = '0;
    evalMode = 2'd0; curInhibit = '0; curForce = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (roundNumber !== 10'd1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reach_round1", roundNumber, 10'd1);
    flips = 0;
    savedState = networkState;
    n = 0;
    while (flips < 2 && n < 5000) begin
      @(negedge clk);
      n++;
      if (networkState !== savedState) flips++;
      savedState = networkState;
    end
    checkOutput("abort_flips_seen", flips, 2);
    initState = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_ignored_busy", busy, 1'b1);
    checkOutput("start_ignored_round", roundNumber, 10'd1);
    abort = 1'b1;
    savedState = networkState;
    savedRound = roundNumber;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_state_hold", networkState, savedState);
    checkOutput("abort_round_hold", roundNumber, savedRound);
    repeat (3) @(negedge clk);
    checkOutput("abort_idle_state_hold", networkState, savedState);
    checkOutput("abort_idle_busy", busy, 1'b0);

    // Restart with seed 0 must follow the seed-1 order
    extraVec = '{64'h0, 8'h00, 8'h00, 8'h00, 10'd2, 2'd0, 1, 8'h00, 10'd2, 1'b0, 1'b1};
    applyStimulus(extraVec, "seed0");

    // Reset asserted mid-run clears everything immediately
    @(negedge clk);
    seed = 64'h3; initState = 8'h00; maxRounds = '0; evalMode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("midrun_reset_outputs",
      {busy, done, steadyState, timeoutFlag, ruleIdx, networkState, roundNumber}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_outputs",
      {busy, done, steadyState, timeoutFlag, ruleIdx, networkState, roundNumber}, '0);

`ifdef GSRO_SYNC_MODE_EN
    @(negedge clk);
    syncMode = 1'b1; evalMode = 2'd3; seed = 64'h42; initState = 8'h01;
    inhibitMask = '0; forceMask = '0; curInhibit = '0; curForce = '0; maxRounds = 10'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("sync_rule_idx", ruleIdx, i);
      if (i < 7) @(negedge clk);
    end
    waitDone(100, "sync");
    checkOutput("sync_state", networkState, 8'h02);
    checkOutput("sync_round", roundNumber, 10'd1);
    checkOutput("sync_timeout", timeoutFlag, 1'b1);
    checkOutput("sync_steady", steadyState, 1'b0);
    syncMode = 1'b0;
`else
    syncMode = 1'b1;
    extraVec = '{64'h42, 8'h00, 8'h00, 8'h00, 10'd2, 2'd0, 1, 8'h00, 10'd2, 1'b0, 1'b1};
    applyStimulus(extraVec, "sync_ignored");
    syncMode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gsro_round_engine.md
# gsro_round_engine

Parametrised update engine for grouped/asynchronous stochastic simulation of a Boolean rule network. It holds the network state and visits every rule exactly once per round, in LFSR-random order. Each visited bit is written from an external combinational rule evaluator, with per-element inhibit (knock-out) and force (knock-in) masks applied. It sits between the host/control wrapper and the generated rule-logic block. It adds a programmable round limit, a configurable steady-state window and an abort.

## Interface
Parameters:
- RULES, 32, number of network elements (≥2)
- LOG_RULES, 5, index width, ≥ clog2(RULES)
- ROUND_W, 10, round counter width
- STEADY_ROUNDS, 2, consecutive unchanged rounds required to declare steady state (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level-sampled; begins a run from IDLE or DONE
- abort  in  1  returns to IDLE from any state; priority over start
- seed  in  64  LFSR seed, sampled on accepted start
- init_state  in  RULES  initial network state, sampled on accepted start
- inhibit_mask  in  RULES  1 forces element to 0, sampled on accepted start
- force_mask  in  RULES  1 forces element to 1 unless inhibited, sampled on accepted start
- max_rounds  in  ROUND_W  round limit; 0 = unlimited; sampled on accepted start
- sync_mode  in  1  1 = synchronous update (only with macro), sampled on accepted start
- rule_idx  out  LOG_RULES  element being evaluated
- next_bit  in  1  evaluator result for rule_idx given network_state
- network_state  out  RULES  current state
- round_number  out  ROUND_W  completed rounds
- busy  out  1  high in SELECT/UPDATE/ROUND_END
- done  out  1  high in DONE
- steady_state  out  1  run ended by steady detection
- timeout  out  1  run ended by round limit

## Operation
Masking: written value = (v | force) & ~inhibit. The same masking applies to init_state at start.

States:
- IDLE: on start, latch inputs, load LFSR with seed (0 is replaced by 1), clear updated/round/stable counters, and load the masked init_state into state and last_state. Then go to SELECT.
- SELECT: LFSR steps every cycle. cand = lfsr[LOG_RULES-1:0].
  - If cand < RULES and updated[cand] = 0: latch cand into rule_idx and go to UPDATE.
  - Otherwise stay in SELECT.
- UPDATE: one cycle. Write state[rule_idx] with the masked next_bit and set updated[rule_idx].
  - If all RULES bits are now updated, go to ROUND_END.
  - Otherwise go to SELECT.
- ROUND_END: one cycle.
  - round_number increments, saturating at all-ones.
  - If state == last_state, stable increments; otherwise stable is cleared.
  - last_state is loaded from state; updated is cleared.
  - If stable reaches STEADY_ROUNDS, go to DONE with steady_state=1.
  - Else if max_rounds≠0 and the new round_number == max_rounds, go to DONE with timeout=1. Steady wins if both occur in the same ROUND_END.
  - Otherwise go to SELECT.
- DONE: outputs hold. start restarts the run exactly as from IDLE.

LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1. It shifts only in SELECT.

Other rules:
- start while busy is ignored.
- abort: clears busy/done/steady_state/timeout and goes to IDLE. state and round_number hold.
- The evaluator sees network_state, which includes all writes from earlier in the current round (asynchronous semantics).

## Timing
- Reset values: state=0, last_state=0, updated=0, lfsr=1, rule_idx=0, round_number=0, all flags 0, FSM=IDLE.
- start→busy: 1 cycle.
- Each element costs ≥2 cycles: ≥1 SELECT plus 1 UPDATE. A round costs ≥2·RULES+1 cycles.
- next_bit is sampled at the UPDATE edge. rule_idx is stable for the whole UPDATE cycle.
- done, steady_state and timeout assert in the cycle after ROUND_END and remain until start or abort.
- Reset asserted mid-run forces the reset values immediately.

## Configuration
- GSRO_SYNC_MODE_EN defined: sync_mode=1 changes the update order and when writes become visible.
  - SELECT is bypassed. rule_idx steps 0..RULES-1, one index per UPDATE cycle.
  - Masked results go to a shadow register; the evaluator still sees the round-start state.
  - The shadow is committed to state at ROUND_END, before the steady compare.
  - The LFSR does not step.
- GSRO_SYNC_MODE_EN undefined: sync_mode is ignored (treated as 0) and no shadow register exists.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles, then release with start=0 → all outputs 0, FSM in IDLE for 10 cycles.
- Random order coverage: RULES=8, seed=64'h1, evaluator returns ~state[idx], max_rounds=4 → each round writes indices 0–7 exactly once; timeout=1 and round_number=4 after round 4; steady_state=0.
- Steady detection: evaluator returns 0, init_state=8'hFF, STEADY_ROUNDS=2 → state=0 after round 1; steady_state=1 with round_number=3.
- Masks: inhibit=8'h01, force=8'h80, evaluator returns 1 → network_state=8'hFE after round 1; bit0 is never 1 and bit7 is never 0 at any cycle.
- Abort/restart: abort mid-round 2 → busy=0 next cycle. A new start with seed=0 behaves identically to seed=1.
- With GSRO_SYNC_MODE_EN and sync_mode=1: evaluator is a one-step rotate, init=8'h01 → state=8'h02 after round 1 and rule_idx=0..7 in order. With the macro undefined, the same stimulus yields random order.
